// File: rtl/axil_pkg.sv
// =============================================================================
// axil_pkg : shared response codes, engine states and address layout for the
//            AXI4-Lite register slave.
// Rev 1.0
// =============================================================================
`default_nettype none

package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam int ADDR_LSB = 2;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

`default_nettype wire

// File: rtl/axil_byte_merge.sv
// =============================================================================
// axil_byte_merge : combinational strobe merge of write data into an old word.
// Rev 1.0
// =============================================================================
`default_nettype none

module axil_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic [DATA_WIDTH-1:0]   o_word
);

  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_byte
    assign o_word[b*8 +: 8] = i_wstrb[b] ? i_wdata[b*8 +: 8] : i_old[b*8 +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/axil_slave_regs.sv
// =============================================================================
// axil_slave_regs : AXI4-Lite slave exposing NUM_REGS 32-bit control registers.
// Optional macro AXIL_SLAVE_REGS_PROT_CHECK_EN rejects non-secure access to reg 0.
// Rev 1.0
// =============================================================================
`default_nettype none

module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W = DATA_WIDTH/8;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_LSB +: IDX_W];
  endfunction

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] hi;
    logic [31:0]           idx;
    hi  = a >> (ADDR_LSB + IDX_W);
    idx = 32'(a[ADDR_LSB +: IDX_W]);
    return (hi == '0) && (idx < 32'(NUM_REGS));
  endfunction

  // Holds READY low until the first edge after reset release.
  logic                  rdy_en_q;

  wstate_e               wstate_q, wstate_d;
  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [2:0]            aw_prot_q, aw_prot_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  resp_t                 bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  rstate_e               rstate_q, rstate_d;
  logic                  ar_pend_q, ar_pend_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;

  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_prot_err, rd_prot_err;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_word;
  logic                  awready, wready, arready;
  logic                  unused_bits;

  assign wr_idx = idx_of(aw_addr_q);
  assign rd_idx = idx_of(ARADDR);

`ifdef AXIL_SLAVE_REGS_PROT_CHECK_EN
  assign wr_prot_err = aw_prot_q[1] && (wr_idx == '0);
  assign rd_prot_err = ARPROT[1] && (rd_idx == '0);
`else
  assign wr_prot_err = 1'b0;
  assign rd_prot_err = 1'b0;
`endif

  assign wr_ok = addr_ok(aw_addr_q) && !wr_prot_err;
  assign rd_ok = addr_ok(ARADDR) && !rd_prot_err;

  always_comb begin
    wr_old  = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_old  = regs_q[i];
      if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
    end
  end

  axil_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .i_old   (wr_old),
    .i_wdata (w_data_q),
    .i_wstrb (w_strb_q),
    .o_word  (wr_merged)
  );

  assign awready = rdy_en_q && (wstate_q == W_IDLE) && !aw_held_q;
  assign wready  = rdy_en_q && (wstate_q == W_IDLE) && !w_held_q;
  assign arready = rdy_en_q && (rstate_q == R_IDLE) && !ar_pend_q;

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    aw_prot_d = aw_prot_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    case (wstate_q)
      W_IDLE: begin
        if (AWVALID && awready) begin
          aw_held_d = 1'b1;
          aw_addr_d = AWADDR;
          aw_prot_d = AWPROT;
        end
        if (WVALID && wready) begin
          w_held_d = 1'b1;
          w_data_d = WDATA;
          w_strb_d = WSTRB;
        end
        if (aw_held_q && w_held_q) begin
          wstate_d = W_RESP;
          if (wr_ok) begin
            bresp_d = RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wr_idx == IDX_W'(i)) regs_d[i] = wr_merged;
            end
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          wstate_d  = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
    endcase
  end

  // Read data is captured on the AR edge (pre-commit) and presented one edge later.
  always_comb begin
    rstate_d  = rstate_q;
    ar_pend_d = ar_pend_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (rstate_q)
      R_IDLE: begin
        if (ar_pend_q) begin
          rstate_d  = R_DATA;
          ar_pend_d = 1'b0;
        end else if (ARVALID && arready) begin
          ar_pend_d = 1'b1;
          rdata_d   = rd_ok ? rd_word : '0;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (RREADY) rstate_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en_q  <= 1'b0;
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      ar_pend_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      rdy_en_q  <= 1'b1;
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      ar_pend_q <= ar_pend_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign AWREADY = awready;
  assign WREADY  = wready;
  assign ARREADY = arready;
  assign BVALID  = (wstate_q == W_RESP);
  assign BRESP   = bresp_q;
  assign RVALID  = (rstate_q == R_DATA);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
  end

  assign unused_bits = ^{aw_prot_q, ARPROT, aw_addr_q[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

endmodule

`default_nettype wire

// File: doc/axil_slave_regs.md
Name: axil_slave_regs

Overview:
- AXI4-Lite slave register file that sits directly downstream of the team's AXI4-Lite link.
- Consumes the master's AW/W/B and AR/R channels.
- Exposes NUM_REGS 32-bit software-programmable control registers to fabric logic.
- Independent write and read engines; one outstanding transaction per direction.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- NUM_REGS, 8, number of registers, 1..256.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- AWVALID/AWREADY  in/out  1  write-address handshake
- AWADDR  in  ADDR_WIDTH  write address
- AWPROT  in  3  write protection
- WVALID/WREADY  in/out  1  write-data handshake
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte enables
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BRESP  out  2  write response
- ARVALID/ARREADY  in/out  1  read-address handshake
- ARADDR  in  ADDR_WIDTH  read address
- ARPROT  in  3  read protection
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- reg_q  out  NUM_REGS*DATA_WIDTH  flat register contents; reg i occupies [i*32 +: 32]

Behaviour:
- Reset (asynchronous, on ARESETN=0):
  - AWREADY, WREADY, BVALID, ARREADY, RVALID = 0.
  - BRESP, RRESP, RDATA = 0; all registers = 0.
  - In-flight transactions are dropped; no response is issued for them.
  - READY signals rise in the first cycle after reset deassertion.
- Decode:
  - index = addr[2 +: IDX_W], where IDX_W = clog2(NUM_REGS), minimum 1.
  - addr[1:0] is ignored.
  - Any nonzero address bit above index, or index >= NUM_REGS, is out of range.
- Write engine, states W_IDLE, W_RESP:
  - In W_IDLE, AWREADY=1 while the AW holding register is empty, and WREADY=1 while the W holding register is empty.
  - AW and W are accepted in either order or in the same cycle.
  - Once both are held, the next edge enters W_RESP, asserts BVALID and commits the write.
  - Latency: AW and W handshake at edge N gives the register update and BVALID=1 at edge N+1.
  - Commit: for each byte b with WSTRB[b]=1, reg[index] byte b = WDATA byte b. WSTRB=0 is legal: OKAY with no change.
  - Out-of-range writes: BRESP=2'b10 (SLVERR), no register changes. Otherwise BRESP=2'b00.
  - BVALID and BRESP hold stable until BREADY. On the B handshake, both holding registers clear and the engine returns to W_IDLE; AWREADY/WREADY are 1 in the following cycle.
- Read engine, states R_IDLE, R_DATA:
  - ARREADY=1 only in R_IDLE.
  - On the AR handshake at edge N: RDATA = reg[index] as sampled before any same-edge write commit; RRESP set; RVALID=1 at edge N+1.
  - Out-of-range reads: RDATA=0, RRESP=SLVERR.
  - RVALID/RDATA/RRESP hold until RREADY; the engine then returns to R_IDLE.
- Concurrency:
  - The read and write engines are fully independent.
  - A read and a write commit to the same register on the same edge return the old value.
- reg_q is driven straight from the registers; a new value is visible the cycle after the commit edge.

Optional Feature:
- Macro AXIL_SLAVE_REGS_PROT_CHECK_EN.
- When defined:
  - A write with AWPROT[1]=1 (non-secure) to register 0 gets SLVERR and does not write.
  - A read with ARPROT[1]=1 of register 0 gets SLVERR with RDATA=0.
  - All other registers are unaffected.
- When undefined, AWPROT and ARPROT are ignored.

Decomposition:
- Package axil_pkg holds:
  - typedef resp_t = logic[1:0], with constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Write-state and read-state enums.
  - Constant ADDR_LSB=2.
- Sub-module axil_byte_merge (combinational): old word + WDATA + WSTRB gives the new word.

Test Plan:
- After reset: AW addr 0x04 and W 0xDEADBEEF/strb 0xF in the same cycle -> BVALID at the next edge, BRESP=00, reg_q[63:32]=0xDEADBEEF.
- W sent 3 cycles before AW (addr 0x08, data 0x12345678), BREADY held low 4 cycles -> WREADY=0 while waiting, BVALID stays high with stable BRESP, reg 2 = 0x12345678.
- Reg 1 = 0xDEADBEEF, then write 0x00AA0000 with strb 0x4 -> reg 1 = 0xDEAABEEF.
- Write to 0x20 with NUM_REGS=8, then read 0x20 -> BRESP=10 and no register change; RRESP=10, RDATA=0.
- Reg 3 = 0x11, then same-edge AR 0x0C and write commit 0x22 to reg 3 -> RDATA=0x11, and a subsequent read returns 0x22.
- ARESETN pulled low while BVALID=1 -> BVALID=0 immediately, all reg_q=0, and a fresh write completes normally afterwards.
